// File: rtl/grn_attractor_ctrl.sv
// Floyd cycle-detection controller for a Boolean GRN node array: finds attractor period and transient.
// Optional GRN_ATTR_STATE_EN adds the attractor_state result port.
module grn_attractor_ctrl #(
   parameter int N_NODES = 16,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               init_valid,
   output logic               init_ready,
   input  logic [N_NODES-1:0] init_vec,
   input  logic [CNT_W-1:0]   max_steps,
   output logic               reset_nos,
   output logic [N_NODES-1:0] init_state,
   output logic               start_s0,
   output logic               start_s1,
   input  logic [N_NODES-1:0] s0_vec,
   input  logic [N_NODES-1:0] s1_vec,
   output logic               result_valid,
   input  logic               result_ready,
   output logic [CNT_W-1:0]   transient,
   output logic [CNT_W-1:0]   period,
   output logic               timeout,
   output logic               busy
`ifdef GRN_ATTR_STATE_EN
   ,
   output logic [N_NODES-1:0] attractor_state
`endif
);

   typedef enum logic [2:0] {IDLE, LOAD1, FLOYD, PERIOD, LOAD2, LEAD, MU, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] max_reg;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] lam;
   logic             ph;
   logic             vec_eq;
   logic             at_max;

   assign vec_eq       = (s0_vec == s1_vec);
   assign at_max       = (cnt == max_reg);
   assign init_ready   = (state == IDLE);
   assign busy         = (state != IDLE);
   assign result_valid = (state == DONE);

   // Steps are registered, so FLOYD/PERIOD skip comparing in the cycle the step is on the wire (ph=1).
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         reset_nos  <= 1'b0;
         init_state <= '0;
         start_s0   <= 1'b0;
         start_s1   <= 1'b0;
         transient  <= '0;
         period     <= '0;
         timeout    <= 1'b0;
         max_reg    <= '0;
         cnt        <= '0;
         lam        <= '0;
         ph         <= 1'b0;
`ifdef GRN_ATTR_STATE_EN
         attractor_state <= '0;
`endif
      end else begin
         reset_nos <= 1'b0;
         start_s0  <= 1'b0;
         start_s1  <= 1'b0;
         case (state)
            IDLE: begin
               if (init_valid) begin
                  init_state <= init_vec;
                  max_reg    <= max_steps;
                  reset_nos  <= 1'b1;
                  state      <= LOAD1;
               end
            end
            LOAD1: begin
               cnt   <= '0;
               ph    <= 1'b0;
               state <= FLOYD;
            end
            FLOYD: begin
               if (ph) begin
                  ph <= 1'b0;
               end else if (cnt != '0 && !cnt[0] && vec_eq) begin
                  cnt   <= '0;
                  state <= PERIOD;
               end else if (at_max) begin
                  transient <= '0;
                  period    <= '0;
                  timeout   <= 1'b1;
`ifdef GRN_ATTR_STATE_EN
                  attractor_state <= '0;
`endif
                  state     <= DONE;
               end else begin
                  start_s0 <= 1'b1;
                  start_s1 <= 1'b1;
                  cnt      <= cnt + 1'b1;
                  ph       <= 1'b1;
               end
            end
            PERIOD: begin
               if (ph) begin
                  ph <= 1'b0;
               end else if (cnt != '0 && vec_eq) begin
                  lam       <= cnt;
                  reset_nos <= 1'b1;
                  state     <= LOAD2;
               end else if (at_max) begin
                  transient <= '0;
                  period    <= '0;
                  timeout   <= 1'b1;
`ifdef GRN_ATTR_STATE_EN
                  attractor_state <= '0;
`endif
                  state     <= DONE;
               end else begin
                  start_s1 <= 1'b1;
                  cnt      <= cnt + 1'b1;
                  ph       <= 1'b1;
               end
            end
            LOAD2: begin
               start_s1 <= 1'b1;
               cnt      <= CNT_W'(1);
               state    <= LEAD;
            end
            LEAD: begin
               if (cnt == lam) begin
                  cnt   <= '0;
                  ph    <= 1'b0;
                  state <= MU;
               end else begin
                  start_s1 <= 1'b1;
                  cnt      <= cnt + 1'b1;
               end
            end
            MU: begin
               // The s0-only pulse in ph=1 is swallowed by the node pass flag, keeping s0 at one step per m.
               if (ph) begin
                  start_s0 <= 1'b1;
                  cnt      <= cnt + 1'b1;
                  ph       <= 1'b0;
               end else if (vec_eq) begin
                  transient <= cnt;
                  period    <= lam;
                  timeout   <= 1'b0;
`ifdef GRN_ATTR_STATE_EN
                  attractor_state <= s0_vec;
`endif
                  state     <= DONE;
               end else begin
                  start_s0 <= 1'b1;
                  start_s1 <= 1'b1;
                  ph       <= 1'b1;
               end
            end
            DONE: begin
               if (result_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// Directed bench for grn_attractor_ctrl with a 3-node behavioural node model.
// Build with GRN_ATTR_STATE_EN to also check attractor_state.
module tb_grn_attractor_ctrl;
   localparam int N = 3;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          init_valid = 1'b0;
   logic          init_ready;
   logic [N-1:0]  init_vec = '0;
   logic [CW-1:0] max_steps = '0;
   logic          reset_nos;
   logic [N-1:0]  init_state;
   logic          start_s0;
   logic          start_s1;
   logic [N-1:0]  s0_vec = '0;
   logic [N-1:0]  s1_vec = '0;
   logic          result_valid;
   logic          result_ready = 1'b1;
   logic [CW-1:0] transient;
   logic [CW-1:0] period;
   logic          timeout;
   logic          busy;
`ifdef GRN_ATTR_STATE_EN
   logic [N-1:0]  attractor_state;
`endif

   int checks = 0;
   int errors = 0;
   int mode = 0;
   int hare_steps = 0;
   logic pass = 1'b1;

   grn_attractor_ctrl #(.N_NODES(N), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .init_valid(init_valid), .init_ready(init_ready),
      .init_vec(init_vec), .max_steps(max_steps),
      .reset_nos(reset_nos), .init_state(init_state),
      .start_s0(start_s0), .start_s1(start_s1),
      .s0_vec(s0_vec), .s1_vec(s1_vec),
      .result_valid(result_valid), .result_ready(result_ready),
      .transient(transient), .period(period),
      .timeout(timeout), .busy(busy)
`ifdef GRN_ATTR_STATE_EN
      , .attractor_state(attractor_state)
`endif
   );

   always #5 clk = ~clk;

   // mode 0: identity, 1: 0->1->2->3->4->2 (others fixed), 2: x+1 mod 8
   function automatic logic [N-1:0] f(input logic [N-1:0] x);
      logic [N-1:0] y;
      y = x;
      if (mode == 1) begin
         case (x)
            3'd0: y = 3'd1;
            3'd1: y = 3'd2;
            3'd2: y = 3'd3;
            3'd3: y = 3'd4;
            3'd4: y = 3'd2;
            default: y = x;
         endcase
      end else if (mode == 2) begin
         y = x + 3'd1;
      end
      return y;
   endfunction

   always @(posedge clk) begin
      if (reset_nos) begin
         s0_vec <= init_state;
         s1_vec <= init_state;
         pass   <= 1'b1;
      end else begin
         if (start_s1) s1_vec <= f(s1_vec);
         if (start_s0) begin
            if (pass) s0_vec <= f(s0_vec);
            pass <= ~pass;
         end
      end
   end

   always @(posedge clk) begin
      if (init_valid && init_ready) hare_steps <= 0;
      else if (start_s1) hare_steps <= hare_steps + 1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
      $display("check %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_init_ready"}, 32'(init_ready), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_valid"}, 32'(result_valid), 32'd0);
      check({tag, "_lines"}, {29'd0, reset_nos, start_s0, start_s1}, 32'd0);
   endtask

   task automatic start_job(input string tag, input logic [N-1:0] iv, input logic [CW-1:0] ms, input int md);
      mode = md;
      init_vec = iv;
      max_steps = ms;
      init_valid = 1'b1;
      tick;
      init_valid = 1'b0;
      check({tag, "_load_pulse"}, 32'(reset_nos), 32'd1);
      check({tag, "_init_state"}, 32'(init_state), 32'(iv));
      check({tag, "_busy"}, 32'(busy), 32'd1);
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!result_valid && n < 3000) begin
         tick;
         n++;
      end
      check({tag, "_valid_seen"}, 32'(result_valid), 32'd1);
   endtask

   task automatic expect_result(input string tag, input int mu, input int lam, input int to);
      wait_valid(tag);
      check({tag, "_transient"}, transient, 32'(mu));
      check({tag, "_period"}, period, 32'(lam));
      check({tag, "_timeout"}, 32'(timeout), 32'(to));
   endtask

   initial begin
      int n;
      tick;
      tick;
      check_idle("reset");
      check("reset_transient", transient, 32'd0);
      check("reset_period", period, 32'd0);
      check("reset_timeout", 32'(timeout), 32'd0);
      rst = 1'b0;
      tick;

      // identity, init 5
      start_job("ident", 3'd5, 32'd100, 0);
      expect_result("ident", 0, 1, 0);
      tick;
      check_idle("ident_after");

      // rho-shaped map, init 0
      start_job("rho", 3'd0, 32'd100, 1);
      expect_result("rho", 2, 3, 0);
`ifdef GRN_ATTR_STATE_EN
      check("rho_attr_state", 32'(attractor_state), 32'd2);
`endif
      tick;
      check_idle("rho_after");

      // 8-cycle counter
      start_job("ring", 3'd0, 32'd100, 2);
      expect_result("ring", 0, 8, 0);
      tick;

      // same map, hare limit 4
      start_job("limit", 3'd0, 32'd4, 2);
      expect_result("limit", 0, 0, 1);
      check("limit_hare_steps", 32'(hare_steps), 32'd4);
`ifdef GRN_ATTR_STATE_EN
      check("limit_attr_state", 32'(attractor_state), 32'd0);
`endif
      tick;

      // zero limit times out straight after the load
      start_job("zero", 3'd3, 32'd0, 2);
      expect_result("zero", 0, 0, 1);
      check("zero_hare_steps", 32'(hare_steps), 32'd0);
      tick;

      // abort in PERIOD
      start_job("abort", 3'd0, 32'd100, 1);
      n = 0;
      while (!(start_s1 && !start_s0) && n < 500) begin
         tick;
         n++;
      end
      check("abort_in_period", 32'(start_s1 && !start_s0), 32'd1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check_idle("abort");
      check("abort_transient", transient, 32'd0);
      check("abort_period", period, 32'd0);
      check("abort_timeout", 32'(timeout), 32'd0);
      start_job("rerun", 3'd0, 32'd100, 1);
      expect_result("rerun", 2, 3, 0);
      tick;

      // result back-pressure
      result_ready = 1'b0;
      start_job("hold", 3'd5, 32'd100, 0);
      wait_valid("hold");
      init_valid = 1'b1;
      init_vec = 3'd2;
      for (int i = 0; i < 10; i++) begin
         tick;
         check("hold_valid", 32'(result_valid), 32'd1);
         check("hold_period", period, 32'd1);
         check("hold_transient", transient, 32'd0);
         check("hold_no_accept", {30'd0, init_ready, reset_nos}, 32'd0);
      end
      init_valid = 1'b0;
      result_ready = 1'b1;
      tick;
      check_idle("hold_release");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
